prog_sequencer: RTL and testbench
=================================

Name: prog_sequencer

Overview:
- Parametrised successor to the fixed fetch path: owns the program counter, the req/done handshake and a runtime-writable jump/branch target table.
- Runs one program from a start address to an end address, honouring stall, jump and taken-branch requests; reports busy, done and a run-cycle count.
- Sits between the top level and instr_ROM; decoder and ALU supply jump, branch, zero and the table indices each cycle.

Parameters:
- D, 10, program counter width; addresses wrap modulo 2^D.
- L, 6, target table index width; table depth 2^L.
- CW, 16, cycle counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- req  in  1  run request; level, held high for the whole run.
- prog_start  in  D  first address; sampled in IDLE when req=1.
- prog_end  in  D  final address; sampled together with prog_start.
- stall  in  1  freeze PC this cycle (RUN only).
- jump  in  1  unconditional redirect to table[jump_idx].
- branch  in  1  conditional redirect to table[branch_idx] when zero=1.
- zero  in  1  ALU zero flag of the current instruction.
- jump_idx  in  L  jump target table index.
- branch_idx  in  L  branch target table index.
- lut_we  in  1  table write enable (honoured in IDLE only).
- lut_waddr  in  L  table write index.
- lut_wdata  in  D  table write data.
- prog_ctr  out  D  current fetch address.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- cycle_cnt  out  CW  cycles spent in RUN for the last/current run.

Behaviour:
- Reset values: state=IDLE, prog_ctr=0, busy=0, done=0, cycle_cnt=0, all table entries=0, end register=0.
- States: IDLE, RUN, DONE. busy=(state==RUN) and done=(state==DONE) are registered state decodes.
- IDLE:
  - lut_we=1 writes table[lut_waddr] <= lut_wdata at the clock edge.
  - req=1 loads prog_ctr <= prog_start, latches prog_end, clears cycle_cnt to 0, goes to RUN. The first fetch is visible the cycle after req is sampled.
  - prog_ctr otherwise holds.
- RUN, evaluated in priority order each cycle:
  - req=0: abort to IDLE; prog_ctr holds; done never asserts.
  - stall=1: prog_ctr holds.
  - prog_ctr == latched end: go to DONE; prog_ctr holds. The end instruction's jump/branch is ignored.
  - jump=1: prog_ctr <= table[jump_idx]. Jump wins over branch.
  - branch=1 and zero=1: prog_ctr <= table[branch_idx].
  - Otherwise: prog_ctr <= prog_ctr+1, wrapping 2^D-1 to 0.
- cycle_cnt: increments on every RUN cycle, including stalled cycles and the end cycle. Saturates at 2^CW-1. Holds in DONE and IDLE.
- DONE: done=1 and prog_ctr holds until req=0. Then IDLE on the next edge (done falls); cycle_cnt is retained.
- lut_we outside IDLE: write ignored, table unchanged.
- Table reads: combinational; an IDLE write is visible from the next cycle.
- prog_start == prog_end: RUN lasts exactly 1 cycle, then DONE; cycle_cnt=1.
- Reset asserted mid-run: immediate return to reset values, including the table.

Decomposition:
- Package prog_seq_pkg: state enum (IDLE, RUN, DONE) and default parameter constants.
- Sub-module target_lut: 2^L x D register array with 1 write port and 2 combinational read ports, async reset.

Test Plan:
- Basic run: reset; prog_start=5, prog_end=9, req=1 held -> prog_ctr 5,6,7,8,9 on consecutive cycles; then done=1, cycle_cnt=5, prog_ctr held at 9. Drop req -> done=0 next cycle, IDLE.
- Table redirect: in IDLE write table[3]=40; run with start=0, end=41; jump=1, jump_idx=3 at pc=2 -> pc 40 next. At pc=40, set branch=1, zero=0 -> pc 41. Repeat a run with zero=1, branch_idx=3 at pc=2 -> pc 40. With jump and branch both asserted and jump_idx pointing at 40 -> pc follows the jump.
- Stall and wrap: D=10, start=1022, end=2; stall=1 for 2 cycles at pc=1023 -> pc sequence 1022,1023,1023,1023,0,1,2; cycle_cnt=7.
- Abort and write lock: drop req at pc=7 of a 5..20 run -> IDLE, pc=7, done stays 0. lut_we during RUN with table[1]=99 -> a later jump_idx=1 still reads the old value.
- Reset mid-run: assert reset at pc=12 -> prog_ctr=0, busy=0, cycle_cnt=0 immediately (asynchronous); table[3] reads 0.
- Single-instruction and saturation: start=end=4 -> one RUN cycle, cycle_cnt=1. With CW=4 and a 20-cycle run -> cycle_cnt=15.

Source files
------------

// File: rtl/prog_seq_pkg.sv
// Shared state encoding and default parameter values for the program sequencer.
package prog_seq_pkg;

  localparam int unsigned D_DEF  = 10;
  localparam int unsigned L_DEF  = 6;
  localparam int unsigned CW_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/prog_sequencer_target_lut.sv
// Jump/branch target table: 2^L entries of D bits, one write port, two
// combinational read ports, cleared by reset.
module prog_sequencer_target_lut
  import prog_seq_pkg::*;
#(
  parameter int unsigned D = D_DEF,
  parameter int unsigned L = L_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [L-1:0] waddr,
  input  logic [D-1:0] wdata,
  input  logic [L-1:0] raddr_a,
  input  logic [L-1:0] raddr_b,
  output logic [D-1:0] rdata_a,
  output logic [D-1:0] rdata_b
);

  logic [D-1:0] mem_q [2**L];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2**L; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: owns the PC, req/done handshake, target table and
// run-cycle counter for one program run from start to end address.
//
// state   | meaning
// IDLE    | waiting for req; table writable
// RUN     | fetching; PC advances, stalls or redirects
// DONE    | end address reached; waits for req to drop
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int unsigned D  = D_DEF,
  parameter int unsigned L  = L_DEF,
  parameter int unsigned CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [D-1:0]  prog_start,
  input  logic [D-1:0]  prog_end,
  input  logic          stall,
  input  logic          jump,
  input  logic          branch,
  input  logic          zero,
  input  logic [L-1:0]  jump_idx,
  input  logic [L-1:0]  branch_idx,
  input  logic          lut_we,
  input  logic [L-1:0]  lut_waddr,
  input  logic [D-1:0]  lut_wdata,
  output logic [D-1:0]  prog_ctr,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cycle_cnt
);

  state_e        state_q, state_d;
  logic [D-1:0]  pc_q, pc_d;
  logic [D-1:0]  end_q, end_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [D-1:0]  jump_tgt, branch_tgt;

  prog_sequencer_target_lut #(.D(D), .L(L)) u_lut (
    .clk     (clk),
    .reset   (reset),
    .we      (lut_we && (state_q == ST_IDLE)),
    .waddr   (lut_waddr),
    .wdata   (lut_wdata),
    .raddr_a (jump_idx),
    .raddr_b (branch_idx),
    .rdata_a (jump_tgt),
    .rdata_b (branch_tgt)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    end_d   = end_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          pc_d    = prog_start;
          end_d   = prog_end;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + 1'b1;
        // The end instruction terminates the run; its own redirects are ignored.
        if (!req)                 state_d = ST_IDLE;
        else if (stall)           pc_d    = pc_q;
        else if (pc_q == end_q)   state_d = ST_DONE;
        else if (jump)            pc_d    = jump_tgt;
        else if (branch && zero)  pc_d    = branch_tgt;
        else                      pc_d    = pc_q + 1'b1;
      end
      ST_DONE: begin
        if (!req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      end_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      end_q   <= end_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign prog_ctr  = pc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: directed scenarios plus random runs, every cycle
// compared against a behavioural model of the run rules.
module tb_prog_sequencer;

  localparam int D = 10;
  localparam int L = 6;

  logic         clk = 1'b0;
  logic         reset;
  logic         req, stall, jump, branch, zero, lut_we;
  logic [D-1:0] prog_start, prog_end, lut_wdata;
  logic [L-1:0] jump_idx, branch_idx, lut_waddr;
  logic [D-1:0] prog_ctr, prog_ctr4;
  logic         busy, done, busy4, done4;
  logic [15:0]  cycle_cnt;
  logic [3:0]   cycle_cnt4;

  always #5 clk = ~clk;

  prog_sequencer #(.D(D), .L(L), .CW(16)) dut (
    .clk(clk), .reset(reset), .req(req), .prog_start(prog_start), .prog_end(prog_end),
    .stall(stall), .jump(jump), .branch(branch), .zero(zero), .jump_idx(jump_idx),
    .branch_idx(branch_idx), .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .prog_ctr(prog_ctr), .busy(busy), .done(done), .cycle_cnt(cycle_cnt)
  );

  prog_sequencer #(.D(D), .L(L), .CW(4)) dut4 (
    .clk(clk), .reset(reset), .req(req), .prog_start(prog_start), .prog_end(prog_end),
    .stall(stall), .jump(jump), .branch(branch), .zero(zero), .jump_idx(jump_idx),
    .branch_idx(branch_idx), .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .prog_ctr(prog_ctr4), .busy(busy4), .done(done4), .cycle_cnt(cycle_cnt4)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: run phase flags, pc, latched end, unsaturated run length.
  int  m_table [64];
  bit  m_running, m_finished;
  int  m_pc, m_end, m_len;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    foreach (m_table[i]) m_table[i] = 0;
    m_running = 0; m_finished = 0;
    m_pc = 0; m_end = 0; m_len = 0;
  endtask

  task automatic model_step();
    if (m_running) begin
      m_len++;
      if (!req)                   m_running = 0;
      else if (stall)             ;
      else if (m_pc == m_end)     begin m_running = 0; m_finished = 1; end
      else if (jump)              m_pc = m_table[jump_idx];
      else if (branch && zero)    m_pc = m_table[branch_idx];
      else                        m_pc = (m_pc + 1) % (1 << D);
    end else if (m_finished) begin
      if (!req) m_finished = 0;
    end else begin
      if (lut_we) m_table[lut_waddr] = int'(lut_wdata);
      if (req) begin
        m_pc = int'(prog_start); m_end = int'(prog_end); m_len = 0; m_running = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("pc",      prog_ctr,   m_pc);
    chk("busy",    busy,       m_running);
    chk("done",    done,       m_finished);
    chk("cnt",     cycle_cnt,  sat(m_len, 65535));
    chk("pc4",     prog_ctr4,  m_pc);
    chk("cnt_sat", cycle_cnt4, sat(m_len, 15));
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic quiet();
    req = 0; stall = 0; jump = 0; branch = 0; zero = 0;
    jump_idx = 0; branch_idx = 0; lut_we = 0; lut_waddr = 0; lut_wdata = 0;
  endtask

  task automatic start_run(input int s, input int e);
    prog_start = D'(s); prog_end = D'(e); req = 1;
    cyc();
  endtask

  task automatic finish_run();
    int budget = 200;
    while (busy && budget > 0) begin cyc(); budget--; end
    chk("run_bound", budget > 0, 1);
    req = 0;
    cyc();
  endtask

  task automatic lut_write(input int a, input int v);
    lut_we = 1; lut_waddr = L'(a); lut_wdata = D'(v);
    cyc();
    lut_we = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    quiet();
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask

  initial begin
    quiet();
    prog_start = 0; prog_end = 0;
    do_reset();
    check_all();
    chk("rst_pc", prog_ctr, 0);
    chk("rst_cnt", cycle_cnt, 0);

    // Basic run 5..9
    start_run(5, 9);
    chk("basic_first", prog_ctr, 5);
    repeat (4) cyc();
    chk("basic_last", prog_ctr, 9);
    cyc();
    chk("basic_done", done, 1);
    chk("basic_cnt", cycle_cnt, 5);
    cyc();
    chk("basic_hold", prog_ctr, 9);
    req = 0;
    cyc();
    chk("basic_done_fall", done, 0);

    // Table redirect: jump, not-taken branch, taken branch, jump beats branch
    lut_write(3, 40);
    start_run(0, 41);
    repeat (2) cyc();
    jump = 1; jump_idx = 3;
    cyc();
    chk("jump_pc", prog_ctr, 40);
    jump = 0; branch = 1; zero = 0;
    cyc();
    chk("branch_nt", prog_ctr, 41);
    branch = 0;
    finish_run();

    start_run(0, 41);
    repeat (2) cyc();
    branch = 1; zero = 1; branch_idx = 3;
    cyc();
    chk("branch_tk", prog_ctr, 40);
    branch = 0; zero = 0;
    finish_run();

    start_run(0, 41);
    repeat (2) cyc();
    jump = 1; jump_idx = 3; branch = 1; zero = 1; branch_idx = 0;
    cyc();
    chk("jump_prio", prog_ctr, 40);
    jump = 0; branch = 0; zero = 0;
    finish_run();

    // Stall and wrap
    start_run(1022, 2);
    cyc();
    stall = 1;
    repeat (2) cyc();
    chk("stall_hold", prog_ctr, 1023);
    stall = 0;
    cyc();
    chk("wrap", prog_ctr, 0);
    repeat (3) cyc();
    chk("wrap_cnt", cycle_cnt, 7);
    chk("wrap_done", done, 1);
    req = 0;
    cyc();

    // Abort and write lock
    start_run(5, 20);
    lut_we = 1; lut_waddr = 1; lut_wdata = 99;
    repeat (2) cyc();
    lut_we = 0; req = 0;
    cyc();
    chk("abort_pc", prog_ctr, 7);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    start_run(50, 60);
    jump = 1; jump_idx = 1;
    cyc();
    chk("wlock_pc", prog_ctr, 0);
    jump = 0;
    req = 0;
    cyc();

    // Reset mid-run
    start_run(10, 30);
    repeat (2) cyc();
    chk("pre_rst_pc", prog_ctr, 12);
    reset = 1;
    #1;
    chk("arst_pc", prog_ctr, 0);
    chk("arst_busy", busy, 0);
    chk("arst_cnt", cycle_cnt, 0);
    do_reset();
    start_run(50, 60);
    jump = 1; jump_idx = 3;
    cyc();
    chk("rst_table", prog_ctr, 0);
    jump = 0; req = 0;
    cyc();

    // Single instruction and saturation
    start_run(4, 4);
    cyc();
    chk("single_done", done, 1);
    chk("single_cnt", cycle_cnt, 1);
    req = 0;
    cyc();
    start_run(100, 119);
    finish_run();
    chk("sat16", cycle_cnt, 20);
    chk("sat4", cycle_cnt4, 15);

    // Random runs
    for (int r = 0; r < 30; r++) begin
      int s, budget;
      quiet();
      repeat ($urandom_range(1, 3)) begin
        lut_we = $urandom_range(0, 1);
        lut_waddr = L'($urandom_range(0, 7));
        lut_wdata = D'($urandom);
        cyc();
      end
      lut_we = 0;
      s = $urandom_range(0, 1023);
      start_run(s, (s + $urandom_range(0, 25)) % 1024);
      budget = 60;
      while (busy && budget > 0) begin
        stall      = ($urandom_range(0, 5) == 0);
        jump       = ($urandom_range(0, 9) == 0);
        branch     = ($urandom_range(0, 3) == 0);
        zero       = $urandom_range(0, 1);
        jump_idx   = L'($urandom_range(0, 7));
        branch_idx = L'($urandom_range(0, 7));
        lut_we     = $urandom_range(0, 1);
        lut_waddr  = L'($urandom_range(0, 7));
        lut_wdata  = D'($urandom);
        if ($urandom_range(0, 39) == 0) req = 0;
        cyc();
        budget--;
      end
      quiet();
      req = done;
      repeat ($urandom_range(0, 2)) cyc();
      req = 0;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
